load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 16, giving the byte-address width.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  CPU access request present.
REQ-005 req_ready  output  1  unit can accept a request (high only in IDLE).
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_error  output  1  misaligned access or reserved size; valid with resp_valid.
REQ-014 mem_addr  output  ADDR_W  word address to memory, with bits [1:0] = 00.
REQ-015 mem_wdata  output  32  full word written to memory.
REQ-016 mem_rdata  input  32  memory read word, combinational from mem_addr while mem_read = 1.
REQ-017 mem_read / mem_write  output  1 each  memory strobes; the memory commits writes on the rising clock edge while mem_write = 1.

Function
REQ-018 FSM states SHALL be IDLE, READ, WRITE, RESP; the state and all outputs SHALL be Moore, decoded from registers.
REQ-019 A request SHALL be accepted on a rising edge with req_valid = 1 in IDLE; addr, size, signed, write and wdata SHALL be latched at that edge.
REQ-020 While not in IDLE, req_valid SHALL be ignored and req_ready SHALL be 0.
REQ-021 Misaligned access (half with addr[0] = 1, word with addr[1:0] != 0) or size 11 SHALL go IDLE->RESP with resp_error = 1 and no mem_read/mem_write.
REQ-022 Load: IDLE->READ->RESP; in READ, mem_read = 1 and mem_rdata is captured at the end of the cycle.
REQ-023 Store word: IDLE->WRITE->RESP; in WRITE, mem_write = 1 and mem_wdata = latched wdata.
REQ-024 Store byte or half: IDLE->READ->WRITE->RESP (read-modify-write); WRITE SHALL drive the captured word with only the target lane(s) replaced.
REQ-025 Byte lanes are little-endian: lane n = bits [8n+7:8n], n = addr[1:0]; the halfword occupies bits [15:0] when addr[1] = 0 and bits [31:16] when addr[1] = 1.
REQ-026 Load extraction SHALL right-justify the selected lane(s); bits above bit 7 (byte) or bit 15 (half) SHALL be filled with the lane MSB if signed = 1, else with 0; word loads are returned unmodified.
REQ-027 RESP SHALL last exactly one cycle with resp_valid = 1, then go to IDLE; a new request can be accepted at the next edge.
REQ-028 Latency from the acceptance edge to the resp_valid cycle SHALL be: error 1 cycle, load and store-word 2 cycles, store byte/half 3 cycles.
REQ-029 mem_read and mem_write SHALL never both be 1; both SHALL be 0 in IDLE and RESP.
REQ-030 mem_addr SHALL be {latched addr[ADDR_W-1:2], 2'b00} in READ and WRITE, and 0 otherwise.
REQ-031 resp_rdata and resp_error SHALL hold their values only during the RESP cycle and SHALL be 0 otherwise.

Reset
REQ-032 Asserting rst SHALL immediately force IDLE and drive mem_read = mem_write = resp_valid = resp_error = 0, resp_rdata = 0, mem_addr = 0, mem_wdata = 0, and clear all latched registers.
REQ-033 With rst asserted, req_ready SHALL be 0; it SHALL be 1 from the first cycle after rst deasserts.
REQ-034 Reset during READ or WRITE SHALL abort the access with no write strobe after reset and no response.

Verification
REQ-035 Load word at 0x0010 with memory word 0x8899AABB -> resp_valid 2 cycles after acceptance, resp_rdata = 0x8899AABB, resp_error = 0.
REQ-036 Load byte at 0x0013 with memory word 0x8899AABB: signed -> 0xFFFFFF88; unsigned -> 0x00000088.
REQ-037 Store half 0x1234 at 0x0022 with memory word 0xDEADBEEF -> one READ cycle, one WRITE with mem_wdata = 0x1234BEEF; resp_valid 3 cycles after acceptance.
REQ-038 Load word at 0x0006 -> resp_error = 1, resp_rdata = 0, resp_valid after 1 cycle, mem_read and mem_write never asserted.
REQ-039 rst asserted during the WRITE cycle of a store byte -> mem_write drops immediately, no resp_valid, memory word unchanged, req_ready = 1 after release.
REQ-040 Back-to-back store word 0x00000055 then load word at 0x0004 with req_valid held high -> second request accepted in the cycle after RESP, load returns 0x00000055.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and memory-side bus between a CPU and the load/store unit.
// The slave modport is the unit's view; master is the CPU-plus-memory side.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_error;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_read;
    logic              mem_write;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               mem_addr, mem_wdata, mem_read, mem_write
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
               mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-wide memory; sub-word
// stores are done as read-modify-write. All outputs come straight from flops.
module load_store_unit #(
    parameter int unsigned ADDR_W = 16
) (
    input logic              clock,
    input logic              rst,
    load_store_unit_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;
    localparam logic [1:0]  SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [1:0]          size_q, size_n;
    logic                signed_q, signed_n;
    logic                write_q, write_n;
    logic                err_q, err_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;

    logic                ready_n, rvalid_n, rerr_n, mread_n, mwrite_n;
    logic [DATA_W-1:0]   rrdata_n, mwdata_n;
    logic [ADDR_W-1:0]   maddr_n;
    logic                misaligned;

    // Right-justify the addressed lane(s) of a memory word and extend.
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] w,
                                                  input logic [1:0]        sz,
                                                  input logic              sg,
                                                  input logic [1:0]        lane);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: extract = {{24{sg & b[7]}}, b};
            SZ_HALF: extract = {{16{sg & h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    // Replace the addressed lane(s) of the captured word with store data.
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] w,
                                                input logic [DATA_W-1:0] d,
                                                input logic [1:0]        sz,
                                                input logic [1:0]        lane);
        merge = w;
        if (sz == SZ_BYTE) begin
            case (lane)
                2'd0:    merge[7:0]   = d[7:0];
                2'd1:    merge[15:8]  = d[7:0];
                2'd2:    merge[23:16] = d[7:0];
                default: merge[31:24] = d[7:0];
            endcase
        end else if (lane[1]) begin
            merge[31:16] = d[15:0];
        end else begin
            merge[15:0] = d[15:0];
        end
    endfunction

    assign misaligned = (bus.req_size == SZ_RSVD)
                      | ((bus.req_size == SZ_HALF) & bus.req_addr[0])
                      | ((bus.req_size == SZ_WORD) & (|bus.req_addr[1:0]));

    // Next state, request latch and next registered outputs.
    always_comb begin
        state_n  = state;
        addr_n   = addr_q;
        size_n   = size_q;
        signed_n = signed_q;
        write_n  = write_q;
        err_n    = err_q;
        wdata_n  = wdata_q;
        ready_n  = 1'b0;
        rvalid_n = 1'b0;
        rerr_n   = 1'b0;
        rrdata_n = '0;
        maddr_n  = '0;
        mwdata_n = '0;
        mread_n  = 1'b0;
        mwrite_n = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    addr_n   = bus.req_addr;
                    size_n   = bus.req_size;
                    signed_n = bus.req_signed;
                    write_n  = bus.req_write;
                    wdata_n  = bus.req_wdata;
                    err_n    = misaligned;
                    if (misaligned)
                        state_n = RESP;
                    else if (bus.req_write && (bus.req_size == SZ_WORD))
                        state_n = WRITE;
                    else
                        state_n = READ;
                end
            end
            READ:    state_n = write_q ? WRITE : RESP;
            WRITE:   state_n = RESP;
            default: state_n = IDLE;
        endcase

        case (state_n)
            IDLE: ready_n = 1'b1;
            READ: begin
                mread_n = 1'b1;
                maddr_n = {addr_n[ADDR_W-1:2], 2'b00};
            end
            WRITE: begin
                mwrite_n = 1'b1;
                maddr_n  = {addr_n[ADDR_W-1:2], 2'b00};
                // Sub-word stores arrive here from READ with the old word on mem_rdata.
                mwdata_n = (state == READ) ? merge(bus.mem_rdata, wdata_q, size_q, addr_q[1:0])
                                           : wdata_n;
            end
            default: begin
                rvalid_n = 1'b1;
                rerr_n   = err_n;
                if ((state == READ) && !write_q)
                    rrdata_n = extract(bus.mem_rdata, size_q, signed_q, addr_q[1:0]);
            end
        endcase
    end

    // State, latched request and output registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            addr_q         <= '0;
            size_q         <= '0;
            signed_q       <= 1'b0;
            write_q        <= 1'b0;
            err_q          <= 1'b0;
            wdata_q        <= '0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_error <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
        end else begin
            state          <= state_n;
            addr_q         <= addr_n;
            size_q         <= size_n;
            signed_q       <= signed_n;
            write_q        <= write_n;
            err_q          <= err_n;
            wdata_q        <= wdata_n;
            bus.req_ready  <= ready_n;
            bus.resp_valid <= rvalid_n;
            bus.resp_error <= rerr_n;
            bus.resp_rdata <= rrdata_n;
            bus.mem_addr   <= maddr_n;
            bus.mem_wdata  <= mwdata_n;
            bus.mem_read   <= mread_n;
            bus.mem_write  <= mwrite_n;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: requests push expected responses
// computed from a byte-lane memory model; a monitor pops and compares.
module tb_load_store_unit;
    localparam int unsigned AW     = 16;
    localparam int unsigned NWORDS = 64;

    typedef struct {
        logic          err;
        logic [31:0]   rdata;
        int            lat;
        int            nrd;
        int            nwr;
        logic [AW-1:0] waddr;
        int            c0;
    } exp_t;

    logic clock;
    logic rst;

    load_store_unit_if #(.ADDR_W(AW)) bus ();
    load_store_unit #(.ADDR_W(AW)) dut (.clock(clock), .rst(rst), .bus(bus));

    logic [31:0] mem     [NWORDS];
    logic [31:0] ref_mem [NWORDS];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;
    int          cyc;
    int          vectors;
    int          miscompares;
    int          n_rd;
    int          n_wr;
    exp_t        exp_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Word memory: combinational read, write committed on the clock edge.
    always @(posedge clock) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (bus.mem_write)
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[7:2]] : 32'h0BAD_F00D;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: memory as bytes, lanes picked by address arithmetic.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [AW-1:0] a, input logic [31:0] wd, output exp_t e);
        int          ai, nb, sh;
        logic [31:0] mask, word, v;
        ai      = int'(a);
        e.waddr = AW'(ai - (ai % 4));
        e.rdata = 32'h0;
        e.err   = (sz == 2'd3) || (sz == 2'd1 && ai % 2 != 0) || (sz == 2'd2 && ai % 4 != 0);
        e.c0    = cyc;
        if (e.err) begin
            e.lat = 1; e.nrd = 0; e.nwr = 0;
            return;
        end
        nb   = 1 << sz;
        sh   = 8 * (ai % 4);
        mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
        word = ref_mem[ai / 4];
        if (!w) begin
            v = (word >> sh) & mask;
            if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
            e.rdata = v; e.lat = 2; e.nrd = 1; e.nwr = 0;
        end else begin
            e.nwr = 1;
            e.nrd = (nb < 4) ? 1 : 0;
            e.lat = (nb < 4) ? 3 : 2;
            ref_mem[ai / 4] = (word & ~(mask << sh)) | ((wd & mask) << sh);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [AW-1:0] a, input logic [31:0] wd,
                         input bit hold, input bit track);
        exp_t e;
        int   n;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) check("ready_timeout", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        if (track) begin
            model(w, sz, sg, a, wd, e);
            exp_q.push_back(e);
        end
        @(negedge clock);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bus.req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = 6'(idx);
        pl_val = val;
        ref_mem[idx] = val;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.mem_read || bus.mem_write) begin
                check("strobe_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
                if (bus.mem_read) n_rd++;
                if (bus.mem_write) n_wr++;
                if (exp_q.size() != 0) check("mem_addr", 32'(bus.mem_addr), 32'(exp_q[0].waddr));
            end
            if (!bus.resp_valid) begin
                check("resp_idle_zero", bus.resp_rdata | 32'(bus.resp_error), 32'd0);
            end else if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_error", 32'(bus.resp_error), 32'(e.err));
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("latency", 32'(cyc - e.c0), 32'(e.lat));
                check("read_cycles", 32'(n_rd), 32'(e.nrd));
                check("write_cycles", 32'(n_wr), 32'(e.nwr));
                n_rd = 0;
                n_wr = 0;
            end
        end
    endtask

    initial begin
        int n;
        logic [1:0] sz;
        logic [AW-1:0] a;
        vectors = 0; miscompares = 0; n_rd = 0; n_wr = 0;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_outputs", bus.mem_wdata | bus.resp_rdata | 32'(bus.resp_error), 32'd0);
        repeat (3) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        check("ready_after_rst", 32'(bus.req_ready), 32'd1);
        fork monitor(); join_none

        for (int i = 0; i < int'(NWORDS); i++) preload(i, $urandom);
        preload(4, 32'h8899_AABB);
        preload(8, 32'hDEAD_BEEF);
        preload(12, 32'hCAFE_F00D);

        // Directed cases.
        issue(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 2'd1, 1'b0, 16'h0022, 32'h0000_1234, 1'b0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 16'h0006, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 2'd3, 1'b0, 16'h0008, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 16'h0004, 32'h0000_0055, 1'b1, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 16'h0004, 32'h0, 1'b0, 1'b1);
        drain();

        // Reset in the WRITE cycle of a byte store must leave memory untouched.
        issue(1'b1, 2'd0, 1'b0, 16'h0031, 32'h0000_00A5, 1'b0, 1'b0);
        n = 0;
        while (!bus.mem_write && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("abort_write_seen", 32'(bus.mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_mem_write", 32'(bus.mem_write), 32'd0);
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd0);
        check("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        repeat (2) @(negedge clock);
        rst = 1'b0;
        n_rd = 0;
        n_wr = 0;
        @(negedge clock);
        check("abort_ready_after", 32'(bus.req_ready), 32'd1);
        issue(1'b0, 2'd2, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b1);
        drain();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            n  = int'($urandom_range(0, 7));
            sz = (n == 7) ? 2'd3 : 2'(n % 3);
            a  = AW'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~AW'((1 << sz) - 1);
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                  1'($urandom_range(0, 1)), 1'b1);
        end
        drain();

        for (int i = 0; i < int'(NWORDS); i++) check("mem_final", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
